// File: rtl/banked_byte_reader_pkg.sv
// Shared types and helpers for the banked byte reader and its lane selector.
package banked_byte_reader_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic MODE_WRAP_WORD = 1'b0;
  localparam logic MODE_LINEAR    = 1'b1;

  // Never returns less than 1, so single-entry dimensions still get a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/byte_lane_sel.sv
// Combinational byte picker: one BYTE_W lane out of one bank word, with an
// error flag for bank indices past NUM_BANKS.
module byte_lane_sel
  import banked_byte_reader_pkg::*;
#(
  parameter  int NUM_BANKS = 4,
  parameter  int WORD_W    = 32,
  parameter  int BYTE_W    = 8,
  localparam int LANES     = WORD_W / BYTE_W,
  localparam int BANK_W    = clog2(NUM_BANKS),
  localparam int LANE_W    = clog2(LANES)
) (
  input  logic [NUM_BANKS*WORD_W-1:0] bank_data_i,
  input  logic [BANK_W-1:0]           bank_i,
  input  logic [LANE_W-1:0]           lane_i,
  output logic [BYTE_W-1:0]           byte_o,
  output logic                        err_o
);

  // Extra bit keeps the compare correct when NUM_BANKS is a power of two.
  assign err_o = {1'b0, bank_i} >= (BANK_W+1)'(NUM_BANKS);

  always_comb begin
    byte_o = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int l = 0; l < LANES; l++) begin
        if (bank_i == BANK_W'(b) && lane_i == LANE_W'(l))
          byte_o = bank_data_i[b*WORD_W + l*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/banked_byte_reader.sv
// Burst byte reader: accepts {bank, lane, len, mode} and streams bytes from the
// live bank words over a registered valid/ready output.
module banked_byte_reader
  import banked_byte_reader_pkg::*;
#(
  parameter  int NUM_BANKS = 4,
  parameter  int WORD_W    = 32,
  parameter  int BYTE_W    = 8,
  parameter  int LEN_W     = 4,
  localparam int LANES     = WORD_W / BYTE_W,
  localparam int BANK_W    = clog2(NUM_BANKS),
  localparam int LANE_W    = clog2(LANES)
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n,
  input  logic [NUM_BANKS*WORD_W-1:0] bank_data,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [BANK_W-1:0]           req_bank,
  input  logic [LANE_W-1:0]           req_byte,
  input  logic [LEN_W-1:0]            req_len,
  input  logic                        req_mode,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BYTE_W-1:0]           out_data,
  output logic                        out_last,
  output logic                        out_err
);

  state_e              state_q, state_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic                mode_q, mode_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                out_valid_q, out_valid_d;
  logic [BYTE_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                out_err_q, out_err_d;

  logic                lane_wrap, bank_at_end;
  logic [BANK_W-1:0]   nxt_bank, sel_bank;
  logic [LANE_W-1:0]   nxt_lane, sel_lane;
  logic [BYTE_W-1:0]   sel_byte;
  logic                sel_err;

  // Address of the beat that follows the one currently presented.
  assign lane_wrap   = (lane_q == LANE_W'(LANES-1));
  assign bank_at_end = {1'b0, bank_q} >= (BANK_W+1)'(NUM_BANKS-1);
  assign nxt_lane    = lane_wrap ? '0 : lane_q + LANE_W'(1);
  assign nxt_bank    = (mode_q == MODE_LINEAR && lane_wrap)
                       ? (bank_at_end ? '0 : bank_q + BANK_W'(1))
                       : bank_q;

  // IDLE loads the first beat from the request; BURST loads the advanced address.
  assign sel_bank = (state_q == IDLE) ? req_bank : nxt_bank;
  assign sel_lane = (state_q == IDLE) ? req_byte : nxt_lane;

  byte_lane_sel #(
    .NUM_BANKS (NUM_BANKS),
    .WORD_W    (WORD_W),
    .BYTE_W    (BYTE_W)
  ) u_sel (
    .bank_data_i (bank_data),
    .bank_i      (sel_bank),
    .lane_i      (sel_lane),
    .byte_o      (sel_byte),
    .err_o       (sel_err)
  );

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    lane_d      = lane_q;
    mode_d      = mode_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_d     = BURST;
            bank_d      = req_bank;
            lane_d      = req_byte;
            mode_d      = req_mode;
            rem_d       = req_len;
            out_valid_d = 1'b1;
            out_data_d  = sel_byte;
            out_err_d   = sel_err;
            out_last_d  = (req_len == '0);
          end
        end
        BURST: begin
          if (out_valid_q && out_ready) begin
            if (rem_q == '0) begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              out_err_d   = 1'b0;
            end else begin
              rem_d       = rem_q - LEN_W'(1);
              bank_d      = nxt_bank;
              lane_d      = nxt_lane;
              out_data_d  = sel_byte;
              out_err_d   = sel_err;
              out_last_d  = (rem_q == LEN_W'(1));
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= IDLE;
      bank_q      <= '0;
      lane_q      <= '0;
      mode_q      <= 1'b0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      lane_q      <= lane_d;
      mode_q      <= mode_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_banked_byte_reader.sv
// Bench for banked_byte_reader: directed table, corner sequences, and random
// bursts scored against an arithmetic model of the addressing rules.
module tb_banked_byte_reader;
  localparam logic [127:0] BD_DEF = 128'h00FFEEDD_CCBBAA99_88776655_44332211;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic [127:0] bd4;
  logic       rv4, rr4, rm4, fl4, ov4, or4, ol4, oe4;
  logic [1:0] rb4, rl4;
  logic [3:0] rlen4;
  logic [7:0] od4;

  // NUM_BANKS = 3 instance
  logic [95:0] bd3;
  logic       rv3, rr3, rm3, fl3, ov3, or3, ol3, oe3;
  logic [1:0] rb3, rl3;
  logic [3:0] rlen3;
  logic [7:0] od3;

  banked_byte_reader u4 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .bank_data(bd4),
    .req_valid(rv4), .req_ready(rr4), .req_bank(rb4), .req_byte(rl4),
    .req_len(rlen4), .req_mode(rm4), .flush(fl4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_last(ol4), .out_err(oe4)
  );

  banked_byte_reader #(.NUM_BANKS(3)) u3 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .bank_data(bd3),
    .req_valid(rv3), .req_ready(rr3), .req_bank(rb3), .req_byte(rl3),
    .req_len(rlen3), .req_mode(rm3), .flush(fl3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_last(ol3), .out_err(oe3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]        bank;
    logic [1:0]        lane;
    logic [3:0]        len;
    logic              mode;
    logic [15:0][7:0]  exp;
  } vec_t;

  vec_t tbl[5];

  // Reference model: expected beats computed from the spec's address rules.
  int ed[16], el[16], ee[16];
  task automatic model(input int nb, input logic [127:0] bd, input int b0, input int l0,
                       input int len, input int mode);
    int b, l;
    logic [127:0] sh;
    b = b0; l = l0;
    for (int i = 0; i <= len; i++) begin
      if (b >= nb) begin
        ed[i] = 0; ee[i] = 1;
      end else begin
        sh = bd >> (b*32 + l*8);
        ed[i] = int'(sh[7:0]); ee[i] = 0;
      end
      el[i] = (i == len) ? 1 : 0;
      l = l + 1;
      if (l == 4) begin
        l = 0;
        if (mode == 1) b = (b + 1 >= nb) ? 0 : b + 1;
      end
    end
  endtask

  task automatic burst4(input string nm, input logic [1:0] b, input logic [1:0] l,
                        input logic [3:0] len, input logic m, input logic [15:0][7:0] exp);
    @(negedge clk);
    chk($sformatf("%s_rdy_in", nm), 32'(rr4), 32'd1);
    rv4 = 1'b1; rb4 = b; rl4 = l; rlen4 = len; rm4 = m; or4 = 1'b1;
    @(negedge clk);
    rv4 = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      chk($sformatf("%s_v%0d", nm, i), 32'(ov4), 32'd1);
      chk($sformatf("%s_d%0d", nm, i), 32'(od4), 32'(exp[i]));
      chk($sformatf("%s_l%0d", nm, i), 32'(ol4), 32'(i == int'(len)));
      chk($sformatf("%s_e%0d", nm, i), 32'(oe4), 32'd0);
      @(negedge clk);
    end
    chk($sformatf("%s_done_v", nm), 32'(ov4), 32'd0);
    chk($sformatf("%s_done_rdy", nm), 32'(rr4), 32'd1);
  endtask

  initial begin
    bd4 = BD_DEF; rv4 = 0; rb4 = 0; rl4 = 0; rlen4 = 0; rm4 = 0; fl4 = 0; or4 = 1;
    bd3 = BD_DEF[95:0]; rv3 = 0; rb3 = 0; rl3 = 0; rlen3 = 0; rm3 = 0; fl3 = 0; or3 = 1;

    tbl[0] = '{2'd1, 2'd2, 4'd0, 1'b0, 128'h77};
    tbl[1] = '{2'd2, 2'd3, 4'd4, 1'b0, 128'hCC_BB_AA_99_CC};
    tbl[2] = '{2'd3, 2'd2, 4'd3, 1'b1, 128'h22_11_00_FF};
    tbl[3] = '{2'd0, 2'd0, 4'd7, 1'b1, 128'h88776655_44332211};
    tbl[4] = '{2'd3, 2'd1, 4'd5, 1'b0, 128'hFF_EE_DD_00_FF_EE};

    // Reset state, and no handshake honoured while reset is held
    rv4 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(ov4), 32'd0);
    chk("rst_data",  32'(od4), 32'd0);
    chk("rst_last",  32'(ol4), 32'd0);
    chk("rst_err",   32'(oe4), 32'd0);
    chk("rst_rdy",   32'(rr4), 32'd1);
    rv4 = 1'b0;
    rst_n = 1'b1;

    foreach (tbl[k])
      burst4($sformatf("tbl%0d", k), tbl[k].bank, tbl[k].lane, tbl[k].len, tbl[k].mode, tbl[k].exp);

    // Stall with live data change: held beat stable, next beat sees new word
    @(negedge clk);
    rv4 = 1'b1; rb4 = 2'd0; rl4 = 2'd0; rlen4 = 4'd3; rm4 = 1'b1; or4 = 1'b1;
    @(negedge clk);
    rv4 = 1'b0;
    chk("stall_d0", 32'(od4), 32'h11);
    @(negedge clk);
    or4 = 1'b0;
    bd4[31:0] = 32'hA4A3A2A1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall_hold_d%0d", i), 32'(od4), 32'h22);
      chk($sformatf("stall_hold_v%0d", i), 32'(ov4), 32'd1);
      chk($sformatf("stall_hold_l%0d", i), 32'(ol4), 32'd0);
    end
    or4 = 1'b1;
    @(negedge clk);
    chk("stall_new_d", 32'(od4), 32'hA3);
    @(negedge clk);
    chk("stall_last_d", 32'(od4), 32'hA4);
    chk("stall_last_l", 32'(ol4), 32'd1);
    @(negedge clk);
    chk("stall_done", 32'(ov4), 32'd0);
    bd4 = BD_DEF;

    // Flush on beat 2 of 5 together with an output handshake and a request
    @(negedge clk);
    rv4 = 1'b1; rb4 = 2'd0; rl4 = 2'd0; rlen4 = 4'd4; rm4 = 1'b0; or4 = 1'b1;
    @(negedge clk);
    rv4 = 1'b0;
    @(negedge clk);
    chk("flush_pre_d", 32'(od4), 32'h22);
    fl4 = 1'b1; rv4 = 1'b1;
    @(negedge clk);
    fl4 = 1'b0; rv4 = 1'b0;
    chk("flush_v", 32'(ov4), 32'd0);
    chk("flush_l", 32'(ol4), 32'd0);
    chk("flush_rdy", 32'(rr4), 32'd1);
    @(negedge clk);
    chk("flush_noreq", 32'(ov4), 32'd0);

    // NUM_BANKS=3: out-of-range bank yields err beat, then bank 0
    @(negedge clk);
    rv3 = 1'b1; rb3 = 2'd3; rl3 = 2'd3; rlen3 = 4'd1; rm3 = 1'b1; or3 = 1'b1;
    @(negedge clk);
    rv3 = 1'b0;
    chk("nb3_d0", 32'(od3), 32'h00);
    chk("nb3_e0", 32'(oe3), 32'd1);
    chk("nb3_l0", 32'(ol3), 32'd0);
    @(negedge clk);
    chk("nb3_d1", 32'(od3), 32'h11);
    chk("nb3_e1", 32'(oe3), 32'd0);
    chk("nb3_l1", 32'(ol3), 32'd1);
    @(negedge clk);
    chk("nb3_done", 32'(ov3), 32'd0);

    // Randomized bursts with random backpressure
    for (int t = 0; t < 40; t++) begin
      int b, l, len, m, idx, cyc;
      logic rdy;
      @(negedge clk);
      bd4 = {$urandom, $urandom, $urandom, $urandom};
      b = int'($urandom_range(0, 3)); l = int'($urandom_range(0, 3));
      len = int'($urandom_range(0, 15)); m = int'($urandom_range(0, 1));
      model(4, bd4, b, l, len, m);
      rv4 = 1'b1; rb4 = 2'(b); rl4 = 2'(l); rlen4 = 4'(len); rm4 = 1'(m); or4 = 1'b1;
      @(negedge clk);
      rv4 = 1'b0;
      idx = 0; cyc = 0;
      while (idx <= len && cyc < 200) begin
        rdy = ($urandom % 4) != 0;
        if (ov4 && rdy) begin
          chk($sformatf("rnd%0d_d%0d", t, idx), 32'(od4), 32'(ed[idx]));
          chk($sformatf("rnd%0d_l%0d", t, idx), 32'(ol4), 32'(el[idx]));
          chk($sformatf("rnd%0d_e%0d", t, idx), 32'(oe4), 32'(ee[idx]));
          idx++;
        end
        or4 = rdy;
        @(negedge clk);
        cyc++;
      end
      if (idx <= len) chk($sformatf("rnd%0d_timeout", t), 32'(idx), 32'(len + 1));
      chk($sformatf("rnd%0d_done", t), 32'(ov4), 32'd0);
      or4 = 1'b1;
    end
    bd4 = BD_DEF;

    // Asynchronous reset mid-burst
    @(negedge clk);
    rv4 = 1'b1; rb4 = 2'd0; rl4 = 2'd0; rlen4 = 4'd7; rm4 = 1'b1; or4 = 1'b1;
    @(negedge clk);
    rv4 = 1'b0;
    @(negedge clk);
    chk("arst_pre_v", 32'(ov4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_v", 32'(ov4), 32'd0);
    chk("arst_d", 32'(od4), 32'd0);
    chk("arst_l", 32'(ol4), 32'd0);
    chk("arst_e", 32'(oe4), 32'd0);
    chk("arst_rdy", 32'(rr4), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_after_v", 32'(ov4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
